// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and the LSU.
// LSU has fixed priority; a saturating starvation counter periodically forces a fetch grant.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic                  if_resp_valid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_LSU} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                kill_q, kill_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                if_forced;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      kill_q      <= kill_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      if_rdata_q  <= if_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  assign if_forced = (starve_q == CNT_W'(STARVE_LIMIT));

  // Arbitration, sequencing and response routing
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    starve_d       = starve_q;
    kill_d         = kill_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    if_rdata_d     = if_rdata_q;
    lsu_rdata_d    = lsu_rdata_q;
    if_req_ready   = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    if_resp_valid  = 1'b0;
    lsu_resp_valid = 1'b0;

    if (state_q != S_IDLE && owner_q == OWN_IF && if_flush) begin
      kill_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Readies are gated by reset so every output reads 0 while it is asserted
        if (lsu_req_valid && !(if_req_valid && if_forced)) begin
          lsu_req_ready = reset;
          owner_d       = OWN_LSU;
          addr_d        = lsu_addr;
          wen_d         = lsu_wen;
          wdata_d       = lsu_wdata;
          wmask_d       = lsu_wmask;
          state_d       = S_REQ;
          if (if_req_valid && !if_forced) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (if_req_valid) begin
          if_req_ready = reset;
          owner_d      = OWN_IF;
          addr_d       = if_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          starve_d     = '0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else begin
            lsu_rdata_d = wen_q ? '0 : mem_rdata;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (owner_q == OWN_IF) begin
          if_resp_valid = !kill_q && !if_flush;
        end else begin
          lsu_resp_valid = 1'b1;
        end
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign if_rdata  = if_rdata_q;
  assign lsu_rdata = lsu_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: one outstanding transaction described by its progress flags
  bit        m_active, m_issued, m_data, m_killed, m_own_lsu;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_lsu_rdata;
  logic      m_wen;
  logic [3:0] m_wmask;
  int        m_starve;
  int        m_log[$];

  function automatic bit exp_lsu_rdy();
    return !m_active && lsu_req_valid && !(if_req_valid && m_starve == LIMIT);
  endfunction

  function automatic bit exp_if_rdy();
    return !m_active && if_req_valid && (!lsu_req_valid || m_starve == LIMIT);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_issued = 0; m_data = 0; m_killed = 0; m_own_lsu = 0;
      m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wmask = '0;
      m_if_rdata = '0; m_lsu_rdata = '0; m_starve = 0;
    end else if (!m_active) begin
      if (exp_lsu_rdy()) begin
        m_active = 1; m_own_lsu = 1; m_issued = 0; m_data = 0;
        m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
        if (if_req_valid && m_starve < LIMIT) m_starve++;
        m_log.push_back(1);
      end else if (exp_if_rdy()) begin
        m_active = 1; m_own_lsu = 0; m_issued = 0; m_data = 0;
        m_addr = if_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
        m_starve = 0;
        m_log.push_back(0);
      end
    end else begin
      if (!m_own_lsu && if_flush) m_killed = 1;
      if (!m_issued) begin
        if (mem_req_ready) m_issued = 1;
      end else if (!m_data) begin
        if (mem_resp_valid) begin
          m_data = 1;
          if (m_own_lsu) m_lsu_rdata = m_wen ? 32'h0 : mem_rdata;
          else m_if_rdata = mem_rdata;
        end
      end else begin
        m_active = 0; m_killed = 0;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (reset) begin
      chk("if_req_ready", 32'(if_req_ready), 32'(exp_if_rdy()));
      chk("lsu_req_ready", 32'(lsu_req_ready), 32'(exp_lsu_rdy()));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(m_active && !m_issued));
      chk("if_resp_valid", 32'(if_resp_valid),
          32'(m_active && m_data && !m_own_lsu && !m_killed && !if_flush));
      chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(m_active && m_data && m_own_lsu));
      chk("busy", 32'(busy), 32'(m_active));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wen", 32'(mem_wen), 32'(m_wen));
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("lsu_rdata", lsu_rdata, m_lsu_rdata);
    end
  end

  // Memory responder state and observation of DUT events
  bit          hs_flag, rv_seen;
  int          stall = 0;
  logic [31:0] next_rdata = '0;
  int          dut_log[$];
  int          if_resp_cnt = 0;
  int          lsu_resp_cnt = 0;

  always @(negedge clk) begin
    hs_flag = mem_req_valid && mem_req_ready;
    rv_seen = mem_req_valid;
    if (reset) begin
      if (if_req_valid && if_req_ready) dut_log.push_back(0);
      if (lsu_req_valid && lsu_req_ready) dut_log.push_back(1);
      if (if_resp_valid) if_resp_cnt++;
      if (lsu_resp_valid) lsu_resp_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rv_seen && stall > 0) stall--;
    mem_req_ready  = (stall == 0);
    mem_resp_valid = hs_flag;
    mem_rdata      = hs_flag ? next_rdata : 32'h0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 32'(busy), 32'(0));
  endtask

  task automatic lsu_req(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm);
    lsu_req_valid = 1'b1; lsu_wen = wen; lsu_addr = a; lsu_wdata = wd; lsu_wmask = wm;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int exp_seq[6];
    exp_seq = '{1, 1, 1, 1, 0, 1};
    if_req_valid = 0; if_addr = '0; if_flush = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = '0;

    // Reset state, with both requesters valid
    repeat (2) @(posedge clk);
    #1;
    if_req_valid = 1; lsu_req_valid = 1;
    #1;
    chk("rst_if_ready", 32'(if_req_ready), 32'(0));
    chk("rst_lsu_ready", 32'(lsu_req_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    if_req_valid = 0; lsu_req_valid = 0;
    reset = 1;
    tick();

    // S1: basic fetch, 4-cycle transaction
    if_req_valid = 1; if_addr = 32'h8000_0000; next_rdata = 32'h0000_0413;
    #1 chk("s1_if_ready_T", 32'(if_req_ready), 32'(1));
    tick(); if_req_valid = 0;
    #1 chk("s1_mem_valid_T1", 32'(mem_req_valid), 32'(1));
    chk("s1_mem_addr_T1", mem_addr, 32'h8000_0000);
    tick(); tick();
    #1 chk("s1_if_resp_T3", 32'(if_resp_valid), 32'(1));
    chk("s1_if_rdata_T3", if_rdata, 32'h0000_0413);
    tick();
    #1 chk("s1_busy_T4", 32'(busy), 32'(0));

    // S2: contended store, LSU wins with starve count 0
    lsu_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    if_req_valid = 1; if_addr = 32'h8000_0004;
    #1 chk("s2_lsu_ready", 32'(lsu_req_ready), 32'(1));
    chk("s2_if_ready", 32'(if_req_ready), 32'(0));
    tick(); lsu_req_valid = 0; if_req_valid = 0; next_rdata = 32'hCAFE_F00D;
    #1 chk("s2_mem_wen", 32'(mem_wen), 32'(1));
    chk("s2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s2_mem_wmask", 32'(mem_wmask), 32'hF);
    tick(); tick();
    #1 chk("s2_lsu_resp", 32'(lsu_resp_valid), 32'(1));
    chk("s2_lsu_rdata_store", lsu_rdata, 32'h0);
    tick(); lsu_wen = 0;

    // S4: fetch squashed in WAIT, then a fetch accepted while if_flush is high in IDLE
    c0 = if_resp_cnt;
    if_req_valid = 1; if_addr = 32'h8000_0008; next_rdata = 32'h1234_5678;
    tick(); if_req_valid = 0;
    tick(); if_flush = 1;
    tick(); if_flush = 0;
    tick();
    #1 chk("s4_busy_T4", 32'(busy), 32'(0));
    chk("s4_no_if_resp", 32'(if_resp_cnt - c0), 32'(0));
    if_req_valid = 1; if_addr = 32'h8000_0010; if_flush = 1; next_rdata = 32'h0010_0093;
    #1 chk("s4_flush_idle_ready", 32'(if_req_ready), 32'(1));
    tick(); if_req_valid = 0; if_flush = 0;
    tick(); tick();
    #1 chk("s4_if_resp_next", 32'(if_resp_valid), 32'(1));
    chk("s4_if_rdata_next", if_rdata, 32'h0010_0093);
    tick();

    // S3: both held valid; starvation guard forces every fifth grant to fetch
    dut_log.delete(); m_log.delete();
    lsu_req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    if_req_valid = 1; if_addr = 32'h8000_0020; next_rdata = 32'h0000_0055;
    for (int i = 0; i < 80 && dut_log.size() < 6; i++) tick();
    lsu_req_valid = 0; if_req_valid = 0;
    chk("s3_grant_count", 32'(dut_log.size() >= 6), 32'(1));
    for (int i = 0; i < 6 && i < dut_log.size(); i++) chk("s3_dut_grant", 32'(dut_log[i]), 32'(exp_seq[i]));
    for (int i = 0; i < 6 && i < m_log.size(); i++) chk("s3_model_grant", 32'(m_log[i]), 32'(exp_seq[i]));
    chk("s3_model_starve", 32'(m_starve), 32'(1));
    wait_idle("s3_idle");

    // S5: memory stalls the request for 5 cycles with fetch waiting
    lsu_req(1'b0, 32'h0000_0300, 32'h0, 4'h0);
    if_req_valid = 1; next_rdata = 32'hA5A5_0300;
    stall = 5; mem_req_ready = 0;
    c0 = lsu_resp_cnt;
    #1 chk("s5_lsu_ready", 32'(lsu_req_ready), 32'(1));
    tick(); lsu_req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("s5_mem_valid_stall", 32'(mem_req_valid), 32'(1));
      chk("s5_mem_addr_stall", mem_addr, 32'h0000_0300);
      chk("s5_if_ready_stall", 32'(if_req_ready), 32'(0));
      chk("s5_mem_ready_low", 32'(mem_req_ready), 32'(0));
      tick();
    end
    if_req_valid = 0;
    wait_idle("s5_idle");
    chk("s5_lsu_resp_once", 32'(lsu_resp_cnt - c0), 32'(1));
    chk("s5_lsu_rdata", lsu_rdata, 32'hA5A5_0300);

    // S6: reset asserted in WAIT, then a clean load
    lsu_req(1'b0, 32'h0000_0400, 32'h0, 4'h0); next_rdata = 32'h0000_0011;
    tick(); lsu_req_valid = 0;
    tick();
    #2 reset = 0;
    #1 chk("s6_rst_busy", 32'(busy), 32'(0));
    chk("s6_rst_mem_valid", 32'(mem_req_valid), 32'(0));
    chk("s6_rst_lsu_resp", 32'(lsu_resp_valid), 32'(0));
    chk("s6_rst_mem_addr", mem_addr, 32'h0);
    chk("s6_rst_lsu_rdata", lsu_rdata, 32'h0);
    tick(); reset = 1;
    tick();
    c0 = lsu_resp_cnt;
    lsu_req(1'b0, 32'h0000_0404, 32'h0, 4'h0); next_rdata = 32'h0000_600D;
    #1 chk("s6_lsu_ready", 32'(lsu_req_ready), 32'(1));
    tick(); lsu_req_valid = 0;
    wait_idle("s6_idle");
    chk("s6_lsu_resp_once", 32'(lsu_resp_cnt - c0), 32'(1));
    chk("s6_lsu_rdata", lsu_rdata, 32'h0000_600D);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
